// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared constants and width helpers for the CIC decimator blocks
package cic_pkg;

  localparam int DEF_OUT_DATA_WIDTH = 18;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Channel index is at least one bit wide so single-channel builds keep a real port.
  function automatic int chan_width(input int channels);
    return (clog2(channels) > 1) ? clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one multi-channel comb stage y = x - x[n-M] with sideband passthrough
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int M        = 1,
  parameter int CHANNELS = 1,
  parameter int W        = DEF_OUT_DATA_WIDTH,
  parameter int CHW      = chan_width(CHANNELS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           in_valid,
  input  logic [CHW-1:0] in_chan,
  input  logic           in_bypass,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  output logic [CHW-1:0] out_chan,
  output logic           out_bypass,
  output logic [W-1:0]   out_data
);

  logic [W-1:0]   hist_q [CHANNELS][M];
  logic [W-1:0]   hist_d [CHANNELS][M];
  logic [W-1:0]   delayed;
  logic           valid_q, valid_d;
  logic           bypass_q, bypass_d;
  logic [CHW-1:0] chan_q, chan_d;
  logic [W-1:0]   data_q, data_d;

  always_comb begin
    hist_d   = hist_q;
    delayed  = '0;
    valid_d  = in_valid & ~clr;
    bypass_d = bypass_q;
    chan_d   = chan_q;
    data_d   = data_q;

    // Channel selection by compare keeps out-of-range indices from touching the array.
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_chan == CHW'(c)) begin
        delayed = hist_q[c][M-1];
        if (in_valid) begin
          hist_d[c][0] = in_data;
          for (int j = 1; j < M; j++) hist_d[c][j] = hist_q[c][j-1];
        end
      end
    end

    if (in_valid) begin
      bypass_d = in_bypass;
      chan_d   = in_chan;
      data_d   = in_bypass ? in_data : in_data - delayed;
    end

    if (clr) hist_d = '{default: '0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q   <= '{default: '0};
      valid_q  <= 1'b0;
      bypass_q <= 1'b0;
      chan_q   <= '0;
      data_q   <= '0;
    end else begin
      hist_q   <= hist_d;
      valid_q  <= valid_d;
      bypass_q <= bypass_d;
      chan_q   <= chan_d;
      data_q   <= data_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_chan   = chan_q;
  assign out_bypass = bypass_q;
  assign out_data   = data_q;

endmodule

// File: rtl/cic_comb_chain.sv
// rtl/cic_comb_chain.sv - N cascaded multi-channel comb stages with channel filter, bypass and clear
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter int M            = 1,
  parameter int N            = 3,
  parameter int CHANNELS     = 1,
  parameter int OutDataWidth = DEF_OUT_DATA_WIDTH,
  parameter int CHW          = chan_width(CHANNELS)
) (
  input  logic                           Clk_i,
  input  logic                           Rst_i,
  input  logic signed [OutDataWidth-1:0] Data_i,
  input  logic                           DataNd_i,
  input  logic [CHW-1:0]                 ChanId_i,
  input  logic                           Bypass_i,
  input  logic                           Clr_i,
  output logic signed [OutDataWidth-1:0] Data_o,
  output logic [CHW-1:0]                 ChanId_o,
  output logic                           DataValid_o
);

  logic [N:0]                   valid_s;
  logic [N:0]                   bypass_s;
  logic [N:0][CHW-1:0]          chan_s;
  logic [N:0][OutDataWidth-1:0] data_s;
  logic                         chan_ok;
  logic                         unused_last_bypass;

  assign chan_ok     = (int'(ChanId_i) < CHANNELS);
  assign valid_s[0]  = DataNd_i & chan_ok;
  assign bypass_s[0] = Bypass_i;
  assign chan_s[0]   = ChanId_i;
  assign data_s[0]   = Data_i;

  // The last stage's registers are the output registers, giving exactly N cycles of latency.
  for (genvar k = 0; k < N; k++) begin : g_stage
    cic_comb_stage #(
      .M        (M),
      .CHANNELS (CHANNELS),
      .W        (OutDataWidth),
      .CHW      (CHW)
    ) u_stage (
      .clk        (Clk_i),
      .rst        (Rst_i),
      .clr        (Clr_i),
      .in_valid   (valid_s[k]),
      .in_chan    (chan_s[k]),
      .in_bypass  (bypass_s[k]),
      .in_data    (data_s[k]),
      .out_valid  (valid_s[k+1]),
      .out_chan   (chan_s[k+1]),
      .out_bypass (bypass_s[k+1]),
      .out_data   (data_s[k+1])
    );
  end

  assign Data_o             = data_s[N];
  assign ChanId_o           = chan_s[N];
  assign DataValid_o        = valid_s[N];
  assign unused_last_bypass = bypass_s[N];

endmodule

// File: tb/tb_cic_comb_chain.sv
// tb/tb_cic_comb_chain.sv - directed checks of cic_comb_chain over several parameter sets
module tb_cic_comb_chain;

  typedef struct {
    int dut;
    int t;
    int d;
    int c;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  got_q[$];
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // a: N1 M1 C1 W18, b: N3 M1 C1, c: W8 N1 M2, d: N2 M1 C2, e: N1 M1 C3
  logic signed [17:0] a_din, a_dout, b_din, b_dout, d_din, d_dout, e_din, e_dout;
  logic signed [7:0]  c_din, c_dout;
  logic a_nd, a_ch, a_byp, a_clr, a_och, a_vld;
  logic b_nd, b_ch, b_byp, b_clr, b_och, b_vld;
  logic c_nd, c_ch, c_byp, c_clr, c_och, c_vld;
  logic d_nd, d_ch, d_byp, d_clr, d_och, d_vld;
  logic e_nd, e_byp, e_clr, e_vld;
  logic [1:0] e_ch, e_och;

  cic_comb_chain #(.M(1), .N(1), .CHANNELS(1), .OutDataWidth(18)) u_a (
    .Clk_i(clk), .Rst_i(rst), .Data_i(a_din), .DataNd_i(a_nd), .ChanId_i(a_ch), .Bypass_i(a_byp),
    .Clr_i(a_clr), .Data_o(a_dout), .ChanId_o(a_och), .DataValid_o(a_vld));
  cic_comb_chain #(.M(1), .N(3), .CHANNELS(1), .OutDataWidth(18)) u_b (
    .Clk_i(clk), .Rst_i(rst), .Data_i(b_din), .DataNd_i(b_nd), .ChanId_i(b_ch), .Bypass_i(b_byp),
    .Clr_i(b_clr), .Data_o(b_dout), .ChanId_o(b_och), .DataValid_o(b_vld));
  cic_comb_chain #(.M(2), .N(1), .CHANNELS(1), .OutDataWidth(8)) u_c (
    .Clk_i(clk), .Rst_i(rst), .Data_i(c_din), .DataNd_i(c_nd), .ChanId_i(c_ch), .Bypass_i(c_byp),
    .Clr_i(c_clr), .Data_o(c_dout), .ChanId_o(c_och), .DataValid_o(c_vld));
  cic_comb_chain #(.M(1), .N(2), .CHANNELS(2), .OutDataWidth(18)) u_d (
    .Clk_i(clk), .Rst_i(rst), .Data_i(d_din), .DataNd_i(d_nd), .ChanId_i(d_ch), .Bypass_i(d_byp),
    .Clr_i(d_clr), .Data_o(d_dout), .ChanId_o(d_och), .DataValid_o(d_vld));
  cic_comb_chain #(.M(1), .N(1), .CHANNELS(3), .OutDataWidth(18)) u_e (
    .Clk_i(clk), .Rst_i(rst), .Data_i(e_din), .DataNd_i(e_nd), .ChanId_i(e_ch), .Bypass_i(e_byp),
    .Clr_i(e_clr), .Data_o(e_dout), .ChanId_o(e_och), .DataValid_o(e_vld));

  always @(negedge clk) begin
    ev_t ev;
    ev.t = cyc;
    if (a_vld === 1'b1) begin ev.dut = 0; ev.d = int'(a_dout); ev.c = int'(a_och); got_q.push_back(ev); end
    if (b_vld === 1'b1) begin ev.dut = 1; ev.d = int'(b_dout); ev.c = int'(b_och); got_q.push_back(ev); end
    if (c_vld === 1'b1) begin ev.dut = 2; ev.d = int'(c_dout); ev.c = int'(c_och); got_q.push_back(ev); end
    if (d_vld === 1'b1) begin ev.dut = 3; ev.d = int'(d_dout); ev.c = int'(d_och); got_q.push_back(ev); end
    if (e_vld === 1'b1) begin ev.dut = 4; ev.d = int'(e_dout); ev.c = int'(e_och); got_q.push_back(ev); end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    a_nd = 1'b0; a_byp = 1'b0; a_clr = 1'b0;
    b_nd = 1'b0; b_byp = 1'b0; b_clr = 1'b0;
    c_nd = 1'b0; c_byp = 1'b0; c_clr = 1'b0;
    d_nd = 1'b0; d_byp = 1'b0; d_clr = 1'b0;
    e_nd = 1'b0; e_byp = 1'b0; e_clr = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      idle_all();
    end
  endtask

  // One strobe on the chosen DUT; when want is set the output is expected cyc+N later.
  task automatic drive(input int dut, input int d, input int ch, input bit byp, input bit clr,
                       input bit want, input int exp_d);
    ev_t ev;
    int  n;
    @(negedge clk);
    idle_all();
    n = 1;
    case (dut)
      0: begin a_din = 18'(d); a_ch = 1'(ch); a_byp = byp; a_clr = clr; a_nd = 1'b1; n = 1; end
      1: begin b_din = 18'(d); b_ch = 1'(ch); b_byp = byp; b_clr = clr; b_nd = 1'b1; n = 3; end
      2: begin c_din = 8'(d);  c_ch = 1'(ch); c_byp = byp; c_clr = clr; c_nd = 1'b1; n = 1; end
      3: begin d_din = 18'(d); d_ch = 1'(ch); d_byp = byp; d_clr = clr; d_nd = 1'b1; n = 2; end
      default: begin e_din = 18'(d); e_ch = 2'(ch); e_byp = byp; e_clr = clr; e_nd = 1'b1; n = 1; end
    endcase
    if (want) begin
      ev.dut = dut; ev.t = cyc + n; ev.d = exp_d; ev.c = ch;
      exp_q.push_back(ev);
    end
  endtask

  task automatic check_run(input string tag);
    chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("%s_dut%0d", tag, i), got_q[i].dut, exp_q[i].dut);
        chk($sformatf("%s_cycle%0d", tag, i), got_q[i].t, exp_q[i].t);
        chk($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_q[i].d);
        chk($sformatf("%s_chan%0d", tag, i), got_q[i].c, exp_q[i].c);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    a_din = '0; a_ch = '0; b_din = '0; b_ch = '0; c_din = '0; c_ch = '0;
    d_din = '0; d_ch = '0; e_din = '0; e_ch = '0;
    idle_all();
    repeat (3) @(negedge clk);
    chk("rst_a_valid", 32'(a_vld), 0);
    chk("rst_a_data", 32'(a_dout), 0);
    chk("rst_a_chan", 32'(a_och), 0);
    chk("rst_b_valid", 32'(b_vld), 0);
    chk("rst_c_data", 32'(c_dout), 0);
    chk("rst_e_chan", 32'(e_och), 0);
    rst = 1'b0;
    got_q.delete();

    // Single-stage impulse
    drive(0, 1, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 1, -1);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(3);
    check_run("a_impulse");

    // Clear drops the concurrent sample and zeroes history; bypass still loads history
    drive(0, 5, 0, 0, 0, 1, 5);
    drive(0, 5, 0, 0, 0, 1, 0);
    drive(0, 9, 0, 0, 1, 0, 0);
    drive(0, 5, 0, 0, 0, 1, 5);
    drive(0, 4, 0, 1, 0, 1, 4);
    drive(0, 6, 0, 0, 0, 1, 2);
    idle(3);
    check_run("a_clear");

    // Three-stage impulse
    drive(1, 1, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 1, -3);
    drive(1, 0, 0, 0, 0, 1, 3);
    drive(1, 0, 0, 0, 0, 1, -1);
    drive(1, 0, 0, 0, 0, 1, 0);
    idle(5);
    check_run("b_impulse");

    // Mid-stream reset with samples in flight
    drive(1, 10, 0, 0, 0, 1, 10);
    idle(5);
    check_run("b_pre");
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 2, 0, 0, 0, 0, 0);
    drive(1, 3, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    idle_all();
    chk("b_rst_valid", 32'(b_vld), 0);
    chk("b_rst_data", 32'(b_dout), 0);
    chk("b_rst_chan", 32'(b_och), 0);
    rst = 1'b0;
    idle(5);
    check_run("b_flushed");
    drive(1, 1, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 1, -3);
    drive(1, 0, 0, 0, 0, 1, 3);
    drive(1, 0, 0, 0, 0, 1, -1);
    idle(5);
    check_run("b_post");

    // 8-bit wrap with M=2 and idle gaps between strobes
    drive(2, 127, 0, 0, 0, 1, 127);
    idle(5);
    drive(2, 0, 0, 0, 0, 1, 0);
    idle(5);
    drive(2, -128, 0, 0, 0, 1, 1);
    idle(3);
    check_run("c_wrap");

    // Two interleaved channels through two stages
    drive(3, 1, 0, 0, 0, 1, 1);
    drive(3, 7, 1, 0, 0, 1, 7);
    drive(3, 0, 0, 0, 0, 1, -2);
    drive(3, 7, 1, 0, 0, 1, -7);
    drive(3, 0, 0, 0, 0, 1, 1);
    drive(3, 7, 1, 0, 0, 1, 0);
    idle(4);
    check_run("d_tdm");

    // Highest legal channel passes, index equal to CHANNELS is dropped
    drive(4, 5, 2, 0, 0, 1, 5);
    drive(4, 9, 3, 0, 0, 0, 0);
    drive(4, 6, 2, 0, 0, 1, 1);
    drive(4, 4, 0, 0, 0, 1, 4);
    idle(3);
    check_run("e_chan");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
